fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
- Frame scheduler between the ADC sample stream, two ping-pong sample banks, the FFT core and the DAC.
- Writes ADC samples into the fill bank. On frame completion it swaps banks and starts the FFT on the filled bank.
- After the FFT finishes, it plays the processed bank out to the DAC, one sample per DAC transfer.
- Sits in fft_top between ADC/DAC and the memory/FFT section; the bank RAMs are external.

Parameters:
- N_PNT, 256, samples per frame; power of two, >= 4.
- ADDR_W, 8, log2(N_PNT).
- DATA_W, 16, sample width.

Ports:
- iCLK  in  1  system clock.
- iRESET  in  1  asynchronous active-low reset.
- iADC_RDY  in  1  one-cycle pulse: iADC_DATA valid.
- iADC_DATA  in  DATA_W  ADC sample.
- oWR_EN  out  1  bank RAM write strobe.
- oWR_BANK  out  1  bank being written.
- oWR_ADDR  out  ADDR_W  write address.
- oWR_DATA  out  DATA_W  write data.
- oFFT_START  out  1  one-cycle pulse: start FFT.
- oFFT_BANK  out  1  bank handed to the FFT and later to playback.
- iFFT_DONE  in  1  one-cycle pulse from the FFT core.
- oRD_ADDR  out  ADDR_W  playback read address; RAM read latency is 1 cycle.
- oDAC_EN  out  1  one-cycle pulse: DAC loads RAM read data.
- iDAC_BUSY  in  1  DAC shifting a sample.
- iOVF_CLR  in  1  clears oOVF.
- oOVF  out  1  sticky: a frame was dropped.
- oFRAME_CNT  out  16  accepted frames, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: all outputs 0; wr_ptr=0; fill bank=0; state IDLE. Reset is asynchronous and takes effect mid-frame or mid-playback; no pending pulse survives.
- Write path, latency 1:
  - iADC_RDY in cycle t -> in cycle t+1: oWR_EN=1, oWR_ADDR=wr_ptr(t), oWR_DATA=iADC_DATA(t), oWR_BANK=fill bank(t).
  - oWR_EN is 0 otherwise; wr_ptr increments by 1 per iADC_RDY.
- Frame complete = iADC_RDY while wr_ptr==N_PNT-1.
- accept = (state==IDLE) or (state==PLAY_EN and rd_ptr==N_PNT-1), i.e. playback finishing in the same cycle counts as free.
- Frame complete with accept:
  - fill bank toggles; wr_ptr->0; oFFT_BANK<=old fill bank.
  - oFFT_START=1 for exactly one cycle (t+1); oFRAME_CNT+1; state->FFT_RUN.
- Frame complete without accept:
  - wr_ptr->0; fill bank unchanged (the frame is overwritten); oOVF<=1.
  - oFRAME_CNT, state and the processing bank are unaffected.
- oOVF: iOVF_CLR clears it; a set in the same cycle as iOVF_CLR wins.
- Processing FSM:
  - IDLE: wait for an accepted frame.
  - FFT_RUN: on iFFT_DONE -> PLAY_RD with rd_ptr=0. iFFT_DONE in any other state is ignored.
  - PLAY_RD: drive oRD_ADDR=rd_ptr with the bank=oFFT_BANK; -> PLAY_EN.
  - PLAY_EN: oDAC_EN=1 for one cycle. If rd_ptr==N_PNT-1 -> IDLE; else rd_ptr+1 -> PLAY_GAP.
  - PLAY_GAP: stay 1 cycle minimum (DAC busy rise time), then wait for iDAC_BUSY==0 -> PLAY_RD.
- oRD_ADDR holds its value outside PLAY_RD.
- Bank ownership: the fill bank is never equal to oFFT_BANK while state != IDLE, except in the accept-in-PLAY_EN cycle, where the swap takes effect after that cycle's read completes.
- Simultaneous iADC_RDY and iFFT_DONE: both are handled independently in the same cycle.
- The FFT operates in place on oFFT_BANK; the controller does not arbitrate FFT RAM accesses.

Test Plan (N_PNT=8, ADDR_W=3):
- Reset, then 8 iADC_RDY pulses with data 1..8 -> 8 writes to bank 0 at addresses 0..7 with data 1..8. One cycle after the 8th pulse: oFFT_START pulse with oFFT_BANK=0; oFRAME_CNT=1; the next sample goes to bank 1, address 0.
- iFFT_DONE with iDAC_BUSY held 0 -> oRD_ADDR steps 0..7 on bank 0, one oDAC_EN per address, 3 cycles apart; state IDLE after the 8th oDAC_EN.
- iDAC_BUSY held 1 for 20 cycles after the first oDAC_EN -> no second oDAC_EN until 2 cycles after BUSY falls.
- A second frame completes while in FFT_RUN -> oOVF=1, no oFFT_START, oFRAME_CNT unchanged, the next sample is written to the same bank at address 0. Then iOVF_CLR -> oOVF=0.
- The 8th sample of the next frame coincides with the last PLAY_EN -> accepted: oFFT_START pulse, oFFT_BANK toggles, oOVF stays 0.
- iRESET asserted in PLAY_GAP after rd_ptr=4 -> all outputs 0 immediately. After release, the next sample goes to bank 0, address 0, and oFRAME_CNT=0.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame scheduler: fills one sample bank from the ADC, hands the
// other to the FFT core, then plays the processed bank out to the DAC.
module fft_frame_ctrl #(
  parameter int N_PNT  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iADC_RDY,
  input  logic [DATA_W-1:0] iADC_DATA,
  output logic              oWR_EN,
  output logic              oWR_BANK,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [DATA_W-1:0] oWR_DATA,
  output logic              oFFT_START,
  output logic              oFFT_BANK,
  input  logic              iFFT_DONE,
  output logic [ADDR_W-1:0] oRD_ADDR,
  output logic              oDAC_EN,
  input  logic              iDAC_BUSY,
  input  logic              iOVF_CLR,
  output logic              oOVF,
  output logic [15:0]       oFRAME_CNT,
  output logic [2:0]        dbg_state
);

  // Handshakes are single-cycle pulses with no back-pressure: iADC_RDY and
  // iFFT_DONE are acted on in the cycle they are high; oFFT_START and oDAC_EN
  // are high for exactly one cycle. iDAC_BUSY is the only level-sensitive
  // flow control and only gates the step from PLAY_GAP to the next read.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FFT_RUN  = 3'd1,
    S_PLAY_RD  = 3'd2,
    S_PLAY_EN  = 3'd3,
    S_PLAY_GAP = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PNT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic              fill_bank;
  logic              frame_done, rd_last, accept, take, drop;

  assign frame_done = iADC_RDY && (wr_ptr == LAST);
  assign rd_last    = (rd_ptr == LAST);
  // A playback finishing in this very cycle frees the processing bank.
  assign accept     = (state == S_IDLE) || ((state == S_PLAY_EN) && rd_last);
  assign take       = frame_done && accept;
  assign drop       = frame_done && !accept;

  assign oDAC_EN   = (state == S_PLAY_EN);
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    case (state)
      S_IDLE: ;
      S_FFT_RUN: begin
        if (iFFT_DONE) begin
          state_nxt  = S_PLAY_RD;
          rd_ptr_nxt = '0;
        end
      end
      S_PLAY_RD: state_nxt = S_PLAY_EN;
      S_PLAY_EN: begin
        if (rd_last) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt  = S_PLAY_GAP;
          rd_ptr_nxt = rd_ptr + 1'b1;
        end
      end
      S_PLAY_GAP: begin
        if (!iDAC_BUSY) state_nxt = S_PLAY_RD;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (take) state_nxt = S_FFT_RUN;
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state    <= S_IDLE;
      rd_ptr   <= '0;
      oRD_ADDR <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      // The read address only moves on entry to PLAY_RD and holds elsewhere.
      if (state_nxt == S_PLAY_RD) oRD_ADDR <= rd_ptr_nxt;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      wr_ptr    <= '0;
      fill_bank <= 1'b0;
      oWR_EN    <= 1'b0;
      oWR_BANK  <= 1'b0;
      oWR_ADDR  <= '0;
      oWR_DATA  <= '0;
    end else begin
      oWR_EN <= iADC_RDY;
      if (iADC_RDY) begin
        oWR_BANK <= fill_bank;
        oWR_ADDR <= wr_ptr;
        oWR_DATA <= iADC_DATA;
        wr_ptr   <= frame_done ? '0 : wr_ptr + 1'b1;
      end
      if (take) fill_bank <= ~fill_bank;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oFFT_START <= 1'b0;
      oFFT_BANK  <= 1'b0;
      oFRAME_CNT <= '0;
      oOVF       <= 1'b0;
    end else begin
      oFFT_START <= take;
      if (take) begin
        oFFT_BANK  <= fill_bank;
        oFRAME_CNT <= oFRAME_CNT + 16'd1;
      end
      // A dropped frame in the same cycle as a clear leaves the flag set.
      if (drop)          oOVF <= 1'b1;
      else if (iOVF_CLR) oOVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl at N_PNT=8: frame fill, FFT hand-off,
// DAC playback pacing, overflow, boundary accept and asynchronous reset.
module tb_fft_frame_ctrl;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 16;

  localparam logic [31:0] ST_IDLE = 0, ST_FFT = 1, ST_RD = 2, ST_GAP = 4;

  logic          iCLK = 1'b0;
  logic          iRESET = 1'b0;
  logic          iADC_RDY = 1'b0;
  logic [DW-1:0] iADC_DATA = '0;
  logic          iFFT_DONE = 1'b0;
  logic          iDAC_BUSY = 1'b0;
  logic          iOVF_CLR = 1'b0;
  logic          oWR_EN, oWR_BANK, oFFT_START, oFFT_BANK, oDAC_EN, oOVF;
  logic [AW-1:0] oWR_ADDR, oRD_ADDR;
  logic [DW-1:0] oWR_DATA;
  logic [15:0]   oFRAME_CNT;
  logic [2:0]    dbg_state;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_e;
  int            n_tests = 0;
  int            n_fail = 0;

  fft_frame_ctrl #(.N_PNT(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iADC_RDY(iADC_RDY), .iADC_DATA(iADC_DATA),
    .oWR_EN(oWR_EN), .oWR_BANK(oWR_BANK), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA),
    .oFFT_START(oFFT_START), .oFFT_BANK(oFFT_BANK), .iFFT_DONE(iFFT_DONE),
    .oRD_ADDR(oRD_ADDR), .oDAC_EN(oDAC_EN), .iDAC_BUSY(iDAC_BUSY),
    .iOVF_CLR(iOVF_CLR), .oOVF(oOVF), .oFRAME_CNT(oFRAME_CNT), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge iCLK);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic bank, input logic [AW-1:0] addr);
    iADC_RDY  = 1'b1;
    iADC_DATA = d;
    tick();
    iADC_RDY  = 1'b0;
    check("wr_en",   32'(oWR_EN),   1);
    check("wr_bank", 32'(oWR_BANK), 32'(bank));
    check("wr_addr", 32'(oWR_ADDR), 32'(addr));
    check("wr_data", 32'(oWR_DATA), 32'(d));
  endtask

  task automatic fft_done_pulse();
    iFFT_DONE = 1'b1;
    tick();
    iFFT_DONE = 1'b0;
  endtask

  task automatic load_playback();
    for (int a = 0; a < N; a++) exp_q.push_back(AW'(a));
  endtask

  task automatic wait_en(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!oDAC_EN && n < 50);
    if (!oDAC_EN) check("dac_en_timeout", 0, 1);
  endtask

  task automatic wait_last_en();
    int n;
    n = 0;
    while (!(oDAC_EN && oRD_ADDR == AW'(N - 1)) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("last_en_timeout", 0, 1);
  endtask

  // ---------------- scoreboard: DAC read addresses ----------------
  always @(negedge iCLK) begin
    if (iRESET && oDAC_EN) begin
      if (exp_q.size() == 0) begin
        check("dac_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("dac_addr", 32'(oRD_ADDR), 32'(mon_e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic quiet;

    // reset state
    tick();
    tick();
    check("rst_wr_en",     32'(oWR_EN), 0);
    check("rst_fft_start", 32'(oFFT_START), 0);
    check("rst_frame_cnt", 32'(oFRAME_CNT), 0);
    check("rst_ovf",       32'(oOVF), 0);
    check("rst_dac_en",    32'(oDAC_EN), 0);
    check("rst_rd_addr",   32'(oRD_ADDR), 0);
    check("rst_state",     32'(dbg_state), ST_IDLE);
    iRESET = 1'b1;
    tick();

    // iFFT_DONE outside FFT_RUN is ignored
    fft_done_pulse();
    check("done_in_idle_state", 32'(dbg_state), ST_IDLE);

    // first frame: data 1..8 into bank 0
    for (int i = 0; i < N; i++) push(DW'(i + 1), 1'b0, AW'(i));
    check("f1_start",     32'(oFFT_START), 1);
    check("f1_fft_bank",  32'(oFFT_BANK), 0);
    check("f1_frame_cnt", 32'(oFRAME_CNT), 1);
    check("f1_state",     32'(dbg_state), ST_FFT);
    tick();
    check("f1_start_pulse", 32'(oFFT_START), 0);
    check("f1_wr_en_idle",  32'(oWR_EN), 0);
    push(16'd9, 1'b1, 3'd0);

    // playback with DAC never busy: one enable every 3 cycles
    load_playback();
    fft_done_pulse();
    check("p1_state_rd", 32'(dbg_state), ST_RD);
    check("p1_rd_addr0", 32'(oRD_ADDR), 0);
    for (int k = 0; k < N; k++) begin
      wait_en(n);
      if (k == 0) check("p1_first_en_lat", 32'(n), 1);
      else        check("p1_en_spacing",   32'(n), 3);
    end
    tick();
    check("p1_state_idle", 32'(dbg_state), ST_IDLE);
    check("p1_dac_en_off", 32'(oDAC_EN), 0);
    check("p1_queue_empty", 32'(exp_q.size()), 0);

    // second frame completes in bank 1
    for (int i = 1; i < N; i++) push(DW'(i + 9), 1'b1, AW'(i));
    check("f2_start",     32'(oFFT_START), 1);
    check("f2_fft_bank",  32'(oFFT_BANK), 1);
    check("f2_frame_cnt", 32'(oFRAME_CNT), 2);

    // frame completing during FFT_RUN is dropped
    for (int i = 0; i < N; i++) push(DW'(32 + i), 1'b0, AW'(i));
    check("ovf_set",       32'(oOVF), 1);
    check("ovf_no_start",  32'(oFFT_START), 0);
    check("ovf_frame_cnt", 32'(oFRAME_CNT), 2);
    check("ovf_state",     32'(dbg_state), ST_FFT);
    check("ovf_fft_bank",  32'(oFFT_BANK), 1);
    push(16'h0030, 1'b0, 3'd0);
    check("ovf_sticky", 32'(oOVF), 1);
    iOVF_CLR = 1'b1;
    tick();
    iOVF_CLR = 1'b0;
    check("ovf_clear", 32'(oOVF), 0);

    // playback of bank 1 with DAC busy held for 20 cycles
    load_playback();
    fft_done_pulse();
    wait_en(n);
    check("p2_first_en_lat", 32'(n), 1);
    iDAC_BUSY = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      tick();
      if (oDAC_EN) quiet = 1'b0;
    end
    check("busy_quiet", 32'(quiet), 1);
    iDAC_BUSY = 1'b0;
    tick();
    check("busy_fall_plus1", 32'(oDAC_EN), 0);
    tick();
    check("busy_fall_plus2", 32'(oDAC_EN), 1);
    check("busy_rd_addr",    32'(oRD_ADDR), 1);

    // next frame's last sample lands on the final PLAY_EN: accepted
    for (int i = 1; i < N - 1; i++) push(DW'(48 + i), 1'b0, AW'(i));
    wait_last_en();
    iADC_RDY  = 1'b1;
    iADC_DATA = 16'h0037;
    tick();
    iADC_RDY  = 1'b0;
    check("edge_start",     32'(oFFT_START), 1);
    check("edge_fft_bank",  32'(oFFT_BANK), 0);
    check("edge_ovf",       32'(oOVF), 0);
    check("edge_frame_cnt", 32'(oFRAME_CNT), 3);
    check("edge_state",     32'(dbg_state), ST_FFT);
    check("edge_wr_bank",   32'(oWR_BANK), 0);
    check("edge_wr_addr",   32'(oWR_ADDR), 7);
    tick();
    check("p2_queue_empty", 32'(exp_q.size()), 0);

    // asynchronous reset in PLAY_GAP with a write strobe pending
    load_playback();
    fft_done_pulse();
    push(16'h0040, 1'b1, 3'd0);
    push(16'h0041, 1'b1, 3'd1);
    n = 0;
    while (!(oDAC_EN && oRD_ADDR == 3'd3) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("gap_en_timeout", 0, 1);
    tick();
    check("pre_rst_state", 32'(dbg_state), ST_GAP);
    iADC_RDY  = 1'b1;
    iADC_DATA = 16'h0042;
    @(posedge iCLK);
    #1;
    check("pre_rst_wr_en", 32'(oWR_EN), 1);
    iADC_RDY = 1'b0;
    iRESET   = 1'b0;
    #1;
    check("arst_wr_en",     32'(oWR_EN), 0);
    check("arst_wr_addr",   32'(oWR_ADDR), 0);
    check("arst_wr_data",   32'(oWR_DATA), 0);
    check("arst_wr_bank",   32'(oWR_BANK), 0);
    check("arst_rd_addr",   32'(oRD_ADDR), 0);
    check("arst_dac_en",    32'(oDAC_EN), 0);
    check("arst_fft_start", 32'(oFFT_START), 0);
    check("arst_fft_bank",  32'(oFFT_BANK), 0);
    check("arst_frame_cnt", 32'(oFRAME_CNT), 0);
    check("arst_state",     32'(dbg_state), ST_IDLE);
    exp_q.delete();
    tick();
    tick();
    iRESET = 1'b1;
    tick();
    push(16'h0055, 1'b0, 3'd0);
    check("post_rst_frame_cnt", 32'(oFRAME_CNT), 0);
    fft_done_pulse();
    check("post_rst_state",  32'(dbg_state), ST_IDLE);
    check("post_rst_dac_en", 32'(oDAC_EN), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
